// File: rtl/bpu_update_ctrl_pkg.sv
// Shared BHT definitions: counter encodings, table geometry, queue entry layout
// and the 2-bit saturating counter update.
package bpu_update_ctrl_pkg;

   localparam int ADDR_W      = 32;
   localparam int BHT_ENTRIES = 256;
   localparam int PQ_ENTRIES  = 4;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam logic [0:0] FSM_INIT = 1'b0;
   localparam logic [0:0] FSM_RUN  = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic              hit;
      logic [1:0]        state;
      logic [ADDR_W-1:0] target;
   } pred_t;

   function automatic logic [1:0] sat_update(input logic [1:0] st, input logic taken);
      if (taken)
         return (st == ST) ? ST : st + 2'd1;
      else
         return (st == SNT) ? SNT : st - 2'd1;
   endfunction

endpackage

// File: rtl/bpu_pred_fifo.sv
// In-flight prediction queue: synchronous FIFO of pred_t with a clear that
// overrides any same-cycle push or pop.
module bpu_pred_fifo
   import bpu_update_ctrl_pkg::*;
#(
   parameter int DEPTH = PQ_ENTRIES,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  pred_t            din,
   input  logic             pop,
   output pred_t            head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   pred_t            mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clear)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bpu_update_ctrl.sv
// BHT sequencer: clears the table after reset, then pairs queued IF predictions with
// ID resolutions to issue BHT writes and fetch redirects (all registered, 1 cycle).
module bpu_update_ctrl
   import bpu_update_ctrl_pkg::*;
#(
   parameter int TABLE_DEPTH = BHT_ENTRIES,
   parameter int Q_DEPTH     = PQ_ENTRIES,
   localparam int IDX_W      = $clog2(TABLE_DEPTH),
   localparam int N          = ADDR_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_pred_valid,
   input  logic [N-1:0]     i_pred_pc,
   input  logic             i_pred_hit,
   input  logic [1:0]       i_pred_state,
   input  logic [N-1:0]     i_pred_target,
   output logic             o_pred_ready,
   input  logic             i_res_valid,
   input  logic             i_res_is_branch,
   input  logic             i_res_taken,
   input  logic [N-1:0]     i_res_target,
   output logic             o_redirect,
   output logic [N-1:0]     o_redirect_pc,
   output logic             o_wr_en,
   output logic             o_wr_alloc,
   output logic [IDX_W-1:0] o_wr_index,
   output logic [N-1:0]     o_wr_pc,
   output logic [N-1:0]     o_wr_target,
   output logic [1:0]       o_wr_state,
   output logic             o_init_busy,
   output logic             o_res_err
);

   localparam int CNT_W = $clog2(Q_DEPTH) + 1;

   logic [0:0]       fsm;
   logic [IDX_W-1:0] sweep;
   logic             fsm_run;
   pred_t            pred_in;
   pred_t            head;
   logic             q_full;
   logic             q_empty;
   logic [CNT_W-1:0] q_count;
   logic             pop;
   logic             pred_taken;
   logic             mispred;
   logic             q_clear;

   logic             redirect_d;
   logic [N-1:0]     redirect_pc_d;
   logic             wr_en_d;
   logic             wr_alloc_d;
   logic [IDX_W-1:0] wr_index_d;
   logic [N-1:0]     wr_pc_d;
   logic [N-1:0]     wr_target_d;
   logic [1:0]       wr_state_d;
   logic             res_err_d;

   assign fsm_run      = (fsm == FSM_RUN);
   assign o_init_busy  = ~fsm_run;
   assign o_pred_ready = fsm_run & ~q_full;

   assign pred_in = '{pc: i_pred_pc, hit: i_pred_hit, state: i_pred_state, target: i_pred_target};

   assign pop        = i_res_valid & fsm_run & ~q_empty;
   assign pred_taken = head.hit & head.state[1];
   assign mispred    = i_res_is_branch
                     ? ((i_res_taken != pred_taken) | (i_res_taken & (i_res_target != head.target)))
                     : pred_taken;
   // A mispredict empties everything behind the popped head, including a same-cycle push.
   assign q_clear    = i_flush | (pop & mispred);
   assign res_err_d  = i_res_valid & (~fsm_run | (q_count == '0));

   bpu_pred_fifo #(.DEPTH(Q_DEPTH)) u_pred_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (q_clear),
      .push  (i_pred_valid & o_pred_ready),
      .din   (pred_in),
      .pop   (pop),
      .head  (head),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   always_comb begin
      redirect_d    = pop & mispred;
      redirect_pc_d = '0;
      wr_en_d       = 1'b0;
      wr_alloc_d    = 1'b0;
      wr_index_d    = '0;
      wr_pc_d       = '0;
      wr_target_d   = '0;
      wr_state_d    = SNT;
      if (redirect_d)
         redirect_pc_d = i_res_taken ? i_res_target : head.pc + N'(4);
      if (!fsm_run) begin
         wr_en_d    = 1'b1;
         wr_alloc_d = 1'b1;
         wr_index_d = sweep;
         wr_state_d = WNT;
      end else if (pop && i_res_is_branch) begin
         wr_en_d     = 1'b1;
         wr_alloc_d  = ~head.hit;
         wr_index_d  = head.pc[IDX_W+1:2];
         wr_pc_d     = head.pc;
         wr_target_d = i_res_target;
         wr_state_d  = head.hit ? sat_update(head.state, i_res_taken)
                                : (i_res_taken ? WT : WNT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm           <= FSM_INIT;
         sweep         <= '0;
         o_redirect    <= 1'b0;
         o_redirect_pc <= '0;
         o_wr_en       <= 1'b0;
         o_wr_alloc    <= 1'b0;
         o_wr_index    <= '0;
         o_wr_pc       <= '0;
         o_wr_target   <= '0;
         o_wr_state    <= '0;
         o_res_err     <= 1'b0;
      end else begin
         if (!fsm_run) begin
            sweep <= sweep + 1'b1;
            if (sweep == IDX_W'(TABLE_DEPTH - 1))
               fsm <= FSM_RUN;
         end
         o_redirect    <= redirect_d;
         o_redirect_pc <= redirect_pc_d;
         o_wr_en       <= wr_en_d;
         o_wr_alloc    <= wr_alloc_d;
         o_wr_index    <= wr_index_d;
         o_wr_pc       <= wr_pc_d;
         o_wr_target   <= wr_target_d;
         o_wr_state    <= wr_state_d;
         o_res_err     <= res_err_d;
      end
   end

endmodule
